// File: rtl/video_probe_tap_if.sv
// -----------------------------------------------------------------------------
// video_probe_tap_if
//   Raw video stream bundle fed from the camera/UDP receive path into the
//   logic-analyzer probe conditioner.
//
//   Signals
//     vs    frame sync (active level chosen by the consumer's VS_POL)
//     de    data enable, high on active pixels
//     data  pixel data, meaningful only while de is high
//
//   Modports
//     master  stream source (drives vs/de/data)
//     slave   stream sink   (samples vs/de/data)
// -----------------------------------------------------------------------------
interface video_probe_tap_if #(
    parameter int PIX_W = 24
);
    logic             vs;
    logic             de;
    logic [PIX_W-1:0] data;

    modport master (output vs, de, data);
    modport slave  (input  vs, de, data);
endinterface

// File: rtl/video_probe_tap.sv
// -----------------------------------------------------------------------------
// video_probe_tap
//   Conditions a video stream into the five probe buses of the on-chip
//   logic-analyzer capture core. Every probe has a fixed 2-clock latency from
//   the stream inputs, so probe0..4 always describe the same pixel.
//
//   Stage 1 registers the raw stream. Stage 2 detects frame/line edges,
//   maintains the pixel/line position counters and checks that every complete
//   line of a frame has the same length as that frame's first line.
//
//   PIX_W must be 24 and 2*CNT_W must be 24 to match the capture core.
//
//   Ports
//     clk          single clock shared with the capture core
//     rst          synchronous, active-high reset
//     vid          stream input (slave modport: vs, de, data)
//     probe0       frame_start pulse (inactive->active vsync edge)
//     probe1       line_start pulse (de 0->1 edge)
//     probe2       de, delay-matched
//     probe3       pixel data, delay-matched, 0 while de is low
//     probe4       {v_cnt, h_cnt} of the pixel on probe3
//     line_len     active pixels in the first line of the last started frame
//     frame_lines  lines counted in the last completed frame
//     len_err      sticky line-length mismatch flag, cleared only by rst
// -----------------------------------------------------------------------------
module video_probe_tap #(
    parameter int PIX_W  = 24,
    parameter int CNT_W  = 12,
    parameter bit VS_POL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    video_probe_tap_if.slave     vid,
    output logic                 probe0,
    output logic                 probe1,
    output logic                 probe2,
    output logic [PIX_W-1:0]     probe3,
    output logic [2*CNT_W-1:0]   probe4,
    output logic [CNT_W-1:0]     line_len,
    output logic [CNT_W-1:0]     frame_lines,
    output logic                 len_err
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    // ---------------- stage 1: input registers ----------------
    // vs_s1 holds vsync normalised to "1 = active". vs/de history registers
    // reset to 1 so a sync or enable already asserted at reset release is
    // not mistaken for a fresh edge.
    logic             s1_valid;
    logic             vs_s1, vs_d;
    logic             de_s1, de_d;
    logic [PIX_W-1:0] data_s1;

    // NOTE: clocked state is written with non-blocking (<=) so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            vs_s1    <= 1'b1;
            vs_d     <= 1'b1;
            de_s1    <= 1'b1;
            de_d     <= 1'b1;
            data_s1  <= '0;
        end else begin
            s1_valid <= 1'b1;
            vs_s1    <= (vid.vs == VS_POL);
            vs_d     <= vs_s1;
            de_s1    <= vid.de;
            de_d     <= de_s1;
            data_s1  <= vid.data;
        end
    end

    // ---------------- stage 2: edge detection ----------------
    logic             frame_start;
    logic             line_start;
    logic             line_end;
    logic             pix_valid;
    logic [CNT_W-1:0] end_count;
    logic [CNT_W-1:0] h_cnt, v_cnt;

    // NOTE: every signal driven here gets a value on every pass through the
    // block; a missed assignment on any path would infer a latch.
    always_comb begin
        frame_start = vs_s1 & ~vs_d;
        line_start  = de_s1 & ~de_d;
        line_end    = ~de_s1 & de_d;
        // stage-1 contents are stale right after reset, so they are not
        // treated as pixels until one real sample has been taken
        pix_valid   = s1_valid & de_s1;
        // h_cnt still holds the index of the line's last pixel here
        end_count   = sat_inc(h_cnt);
    end

    // ---------------- stage 2: counters, checks, probes ----------------
    logic [CNT_W-1:0] line_cnt;   // lines started in the current frame
    logic             first_line; // next line_start opens line 0 of a frame
    logic             line_ok;    // current line began inside the current frame

    always_ff @(posedge clk) begin
        if (rst) begin
            probe0      <= 1'b0;
            probe1      <= 1'b0;
            probe2      <= 1'b0;
            probe3      <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_cnt    <= '0;
            first_line  <= 1'b1;
            line_ok     <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            len_err     <= 1'b0;
        end else begin
            probe0 <= frame_start;
            probe1 <= line_start;
            probe2 <= pix_valid;
            probe3 <= pix_valid ? data_s1 : '0;

            if (pix_valid) begin
                h_cnt <= line_start ? '0 : sat_inc(h_cnt);
            end

            if (frame_start) begin
                // Frame start wins over everything else. A line already in
                // progress loses line_ok, so its end is neither latched nor
                // checked; a line starting in this very cycle is line 0.
                frame_lines <= line_cnt;
                line_cnt    <= line_start ? CNT_W'(1) : '0;
                v_cnt       <= '0;
                first_line  <= ~line_start;
                line_ok     <= line_start;
            end else if (line_start) begin
                line_cnt   <= sat_inc(line_cnt);
                v_cnt      <= first_line ? '0 : sat_inc(v_cnt);
                first_line <= 1'b0;
                line_ok    <= 1'b1;
            end else if (line_end && line_ok) begin
                line_ok <= 1'b0;
                // only line 0 of a frame can end with v_cnt still at 0
                if (v_cnt == '0) begin
                    line_len <= end_count;
                end else if (end_count != line_len) begin
                    len_err <= 1'b1;
                end
            end
        end
    end

    assign probe4 = {v_cnt, h_cnt};

endmodule
